if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the RV64 pipeline, directly upstream of the decode stage.
- Holds the 64-bit PC and issues one-outstanding fetch requests to instruction memory.
- Buffers returned 32-bit instructions with their PC in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (taken branch/jump) from execute; a redirect flushes the FIFO and discards any in-flight response.

Parameters:
- XLEN, 64, PC and address width.
- RESET_PC, 64'h0, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request strobe, held exactly one cycle per request.
- imem_addr  out  XLEN  fetch address, valid while imem_req=1.
- imem_rvalid  in  1  response strobe; one response per request, latency >=1 cycle, variable.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- redir_valid  in  1  redirect request from execute.
- redir_pc  in  XLEN  redirect target.
- inst_valid  out  1  FIFO head valid to decode.
- inst  out  32  FIFO head instruction.
- inst_pc  out  XLEN  PC of FIFO head instruction.
- id_ready  in  1  decode accepts the head this cycle.
- misalign_err  out  1  one-cycle pulse when redir_pc[1:0]!=0.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC; FIFO empty; state=IDLE; discard=0.
  - imem_req=0, imem_addr=0, misalign_err=0.
  - inst_valid=0, inst=NOP (32'h00000013), inst_pc=0.
  - Reset mid-transaction abandons the outstanding request; a response arriving after reset is ignored because state=IDLE.
- FSM states: IDLE, WAIT.
  - IDLE: if (count + 0) < FIFO_DEPTH and no redirect this cycle, then next cycle imem_req=1, imem_addr=pc, req_pc<=pc, state->WAIT. Otherwise stay.
  - WAIT, imem_rvalid=1, discard=0: push {req_pc, imem_rdata}; pc<=req_pc+4, mod 2^XLEN with silent wrap.
  - WAIT, imem_rvalid=1, discard=1: drop the word; discard<=0.
  - WAIT, any response: state->IDLE. The next request issues no earlier than the following cycle, so at most one request is outstanding.
  - Space check counts the outstanding slot: a request is issued only if count+1 <= FIFO_DEPTH after pending pops are accounted for, so a response never overflows the FIFO.
- Redirect (redir_valid=1 at posedge):
  - pc<=redir_pc with bits [1:0] forced to 0; FIFO flushed (count=0).
  - If state=WAIT and no imem_rvalid this cycle: discard<=1.
  - If imem_rvalid coincides with the redirect, the word is dropped and state->IDLE.
  - misalign_err=1 for one cycle if redir_pc[1:0]!=0.
  - Redirect has priority over push, pop and request issue.
  - First request to the new PC: next cycle if IDLE; one cycle after the discarded response arrives otherwise.
- Decode handshake:
  - inst_valid = FIFO non-empty (registered count).
  - inst/inst_pc = head entry; inst = NOP when empty.
  - Pop when inst_valid && id_ready && !redir_valid.
  - Push and pop in the same cycle keep count unchanged.
- Latency: response at posedge N -> inst_valid=1 at posedge N+1, with empty FIFO.
- Invariants: count <= FIFO_DEPTH; imem_req is never asserted while state=WAIT.

Decomposition:
- Shared package cpu_pkg: XLEN, NOP_INST=32'h00000013, RESET_PC default, fetch state enum {IDLE, WAIT}, RV opcode constants shared with the decode stage.
- Sub-module if_fifo: synchronous FIFO of {pc, inst}, parameterised depth.
  - Ports: push, pop, flush, count, head outputs.
  - Flush has priority over push and pop.

Test Plan:
- Reset, 1-cycle-latency memory returning addr-derived words, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; inst_pc follows, one instruction per 2 cycles.
- id_ready=0 for 10 cycles -> exactly 2 requests issued (0x0, 0x4); imem_req stays 0 while full. Raising id_ready resumes fetch at 0x8.
- Redirect to 0x1000 while a request to 0x8 is in WAIT, response 3 cycles later -> 0x8 word never appears on inst; next imem_addr=0x1000; FIFO empty the cycle after redirect.
- Redirect and imem_rvalid in the same cycle -> response dropped; next request 0x2000; inst_valid=0 the next cycle.
- Redirect to 0x1002 -> misalign_err pulses one cycle; next imem_addr=0x1000.
- PC=0xFFFF_FFFF_FFFF_FFFC fetch -> next imem_addr=0x0. Reset asserted in WAIT -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch and decode stages of the RV64 pipeline.
package cpu_pkg;

   localparam int unsigned       XLEN          = 64;
   localparam logic [31:0]       NOP_INST      = 32'h0000_0013;
   localparam logic [XLEN-1:0]   RESET_PC_DFLT = '0;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/if_fifo.sv
// Synchronous {pc, inst} buffer between fetch and decode; flush wins over push and pop.
module if_fifo #(
   parameter int DEPTH = 2,
   parameter int PC_W  = 64,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic            i_flush,
   input  logic [PC_W-1:0] i_pc,
   input  logic [31:0]     i_inst,
   output logic [CW-1:0]   o_count,
   output logic [PC_W-1:0] o_head_pc,
   output logic [31:0]     o_head_inst
);

   logic [PC_W+31:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   always_comb begin
      w_do_push = i_push && !i_flush && (r_count < CW'(DEPTH));
      w_do_pop  = i_pop && !i_flush && (r_count != '0);
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: nothing is read while the count is zero.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= {i_pc, i_inst};
   end

   assign o_count     = r_count;
   assign o_head_pc   = r_mem[r_rd_ptr][PC_W+31:32];
   assign o_head_inst = r_mem[r_rd_ptr][31:0];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: single outstanding imem request, small buffer toward decode, redirect flush.
// state | meaning
// IDLE  | no request outstanding; issues the next fetch when the buffer has room
// WAIT  | one request outstanding; the response is buffered or, after a redirect, dropped
module if_stage #(
   parameter int unsigned     XLEN       = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = cpu_pkg::RESET_PC_DFLT,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            redir_valid,
   input  logic [XLEN-1:0] redir_pc,
   output logic            inst_valid,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            id_ready,
   output logic            misalign_err
);

   import cpu_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_e    r_state;
   fetch_state_e    w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] r_req_pc;
   logic [XLEN-1:0] w_req_pc_nxt;
   logic            r_discard;
   logic            w_discard_nxt;
   logic            r_imem_req;
   logic            w_imem_req_nxt;
   logic [XLEN-1:0] r_imem_addr;
   logic [XLEN-1:0] w_imem_addr_nxt;
   logic            r_misalign;
   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_count_after;
   logic            w_push;
   logic            w_pop;
   logic            w_issue;
   logic            w_inst_valid;
   logic [XLEN-1:0] w_head_pc;
   logic [31:0]     w_head_inst;

   if_fifo #(
      .DEPTH (int'(FIFO_DEPTH)),
      .PC_W  (int'(XLEN))
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_flush     (redir_valid),
      .i_pc        (r_req_pc),
      .i_inst      (imem_rdata),
      .o_count     (w_count),
      .o_head_pc   (w_head_pc),
      .o_head_inst (w_head_inst)
   );

   // Room is judged after this cycle's pop so a full buffer being drained refetches at once.
   always_comb begin
      w_inst_valid  = (w_count != '0);
      w_pop         = w_inst_valid && id_ready && !redir_valid;
      w_push        = (r_state == WAIT) && imem_rvalid && !r_discard && !redir_valid;
      w_count_after = w_count - CW'(w_pop);
      w_issue       = (r_state == IDLE) && !redir_valid && (w_count_after < CW'(FIFO_DEPTH));
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_req_pc_nxt    = r_req_pc;
      w_discard_nxt   = r_discard;
      w_imem_req_nxt  = 1'b0;
      w_imem_addr_nxt = r_imem_addr;
      case (r_state)
         IDLE: begin
            if (w_issue) begin
               w_state_nxt     = WAIT;
               w_imem_req_nxt  = 1'b1;
               w_imem_addr_nxt = r_pc;
               w_req_pc_nxt    = r_pc;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               w_state_nxt   = IDLE;
               w_discard_nxt = 1'b0;
               if (w_push) w_pc_nxt = r_req_pc + XLEN'(4);
            end else if (redir_valid) begin
               w_discard_nxt = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (redir_valid) w_pc_nxt = {redir_pc[XLEN-1:2], 2'b00};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pc        <= RESET_PC;
         r_req_pc    <= RESET_PC;
         r_discard   <= 1'b0;
         r_imem_req  <= 1'b0;
         r_imem_addr <= '0;
         r_misalign  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_req_pc    <= w_req_pc_nxt;
         r_discard   <= w_discard_nxt;
         r_imem_req  <= w_imem_req_nxt;
         r_imem_addr <= w_imem_addr_nxt;
         r_misalign  <= redir_valid && (redir_pc[1:0] != 2'b00);
      end
   end

   assign imem_req     = r_imem_req;
   assign imem_addr    = r_imem_addr;
   assign misalign_err = r_misalign;
   assign inst_valid   = w_inst_valid;
   assign inst         = w_inst_valid ? w_head_inst : NOP_INST;
   assign inst_pc      = w_inst_valid ? w_head_pc : '0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: queued expected fetch addresses and decoded words, popped by monitors.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redir_valid = 1'b0;
   logic [63:0] redir_pc = 64'h0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        id_ready = 1'b0;
   logic        misalign_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] exp_addr [$];
   logic [95:0] exp_inst [$];
   logic [95:0] mon_e;

   int          mem_lat  = 1;
   int          mem_cnt  = 0;
   bit          mem_busy = 1'b0;
   logic [63:0] mem_addr = 64'h0;
   int          reqs;

   always #5 clk = ~clk;

   if_stage #(
      .XLEN       (64),
      .RESET_PC   (64'h0),
      .FIFO_DEPTH (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .redir_valid  (redir_valid),
      .redir_pc     (redir_pc),
      .inst_valid   (inst_valid),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .id_ready     (id_ready),
      .misalign_err (misalign_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic exp_a(input logic [63:0] a);
      exp_addr.push_back(a);
   endtask

   task automatic exp_i(input logic [63:0] pc, input logic [31:0] w);
      exp_inst.push_back({pc, w});
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      redir_valid = 1'b0;
      id_ready    = 1'b0;
      step();
      step();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_imem_req"},     64'(imem_req),     64'h0);
      chk({tag, "_imem_addr"},    imem_addr,         64'h0);
      chk({tag, "_misalign_err"}, 64'(misalign_err), 64'h0);
      chk({tag, "_inst_valid"},   64'(inst_valid),   64'h0);
      chk({tag, "_inst"},         64'(inst),         64'h13);
      chk({tag, "_inst_pc"},      inst_pc,           64'h0);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_inst.size() != 0 && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_drain_left"}, 64'(exp_inst.size()), 64'h0);
   endtask

   // Instruction memory: response word is address-derived, delivered mem_lat edges after the request.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (rst) begin
            mem_busy = 1'b0;
         end else begin
            if (imem_req) begin
               if (mem_busy) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL imem_overlap: request %0h while %0h outstanding, required none", imem_addr, mem_addr);
               end
               mem_busy = 1'b1;
               mem_cnt  = mem_lat;
               mem_addr = imem_addr;
            end
            if (mem_busy) begin
               if (mem_cnt <= 1) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = mem_addr[31:0] + 32'h0001_0013;
                  mem_busy    = 1'b0;
               end else begin
                  mem_cnt--;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (imem_req) begin
            if (exp_addr.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL imem_addr_unexpected: got %0h, required no request", imem_addr);
            end else begin
               chk("imem_addr", imem_addr, exp_addr.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && inst_valid && id_ready && !redir_valid) begin
            if (exp_inst.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL inst_unexpected: got pc %0h inst %0h, required nothing", inst_pc, inst);
            end else begin
               mon_e = exp_inst.pop_front();
               chk("inst_pc", inst_pc, mon_e[95:32]);
               chk("inst", 64'(inst), 64'(mon_e[31:0]));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      // Reset values
      step();
      step();
      chk_reset_outputs("rst0");

      // Streaming with 1-cycle memory and decode always ready
      rst      = 1'b0;
      id_ready = 1'b1;
      mem_lat  = 1;
      exp_a(64'h0); exp_a(64'h4); exp_a(64'h8); exp_a(64'hC);
      exp_i(64'h0, 32'h0001_0013);
      exp_i(64'h4, 32'h0001_0017);
      exp_i(64'h8, 32'h0001_001B);
      drain("stream");

      // Decode stalled: buffer fills after two fetches, then resumes at 0x8
      do_reset();
      rst      = 1'b0;
      id_ready = 1'b0;
      mem_lat  = 1;
      exp_a(64'h0); exp_a(64'h4); exp_a(64'h8); exp_a(64'hC);
      exp_i(64'h0, 32'h0001_0013);
      exp_i(64'h4, 32'h0001_0017);
      exp_i(64'h8, 32'h0001_001B);
      reqs = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (imem_req) reqs++;
      end
      chk("stall_req_count", 64'(reqs), 64'd2);
      chk("stall_req_full", 64'(imem_req), 64'h0);
      chk("stall_valid_full", 64'(inst_valid), 64'h1);
      id_ready = 1'b1;
      step();
      chk("resume_req", 64'(imem_req), 64'h1);
      chk("resume_addr", imem_addr, 64'h8);
      drain("resume");

      // Redirect while the 0x8 fetch waits on a 3-cycle response; buffered 0x4 is flushed
      do_reset();
      rst      = 1'b0;
      id_ready = 1'b1;
      mem_lat  = 1;
      exp_a(64'h0); exp_a(64'h4); exp_a(64'h8); exp_a(64'h1000); exp_a(64'h1004);
      exp_i(64'h0, 32'h0001_0013);
      exp_i(64'h1000, 32'h0001_1013);
      repeat (4) step();
      id_ready = 1'b0;
      mem_lat  = 3;
      step();
      chk("wait8_req", 64'(imem_req), 64'h1);
      chk("wait8_addr", imem_addr, 64'h8);
      redir_valid = 1'b1;
      redir_pc    = 64'h1000;
      step();
      redir_valid = 1'b0;
      mem_lat     = 1;
      id_ready    = 1'b1;
      chk("redir_flush_valid", 64'(inst_valid), 64'h0);
      chk("redir_aligned_err", 64'(misalign_err), 64'h0);
      drain("redir_wait");

      // Redirect coinciding with the response
      do_reset();
      rst      = 1'b0;
      id_ready = 1'b1;
      mem_lat  = 1;
      exp_a(64'h0); exp_a(64'h2000); exp_a(64'h2004);
      exp_i(64'h2000, 32'h0001_2013);
      step();
      redir_valid = 1'b1;
      redir_pc    = 64'h2000;
      step();
      redir_valid = 1'b0;
      chk("redir_rvalid_valid", 64'(inst_valid), 64'h0);
      drain("redir_rvalid");

      // Misaligned redirect target
      do_reset();
      rst         = 1'b0;
      id_ready    = 1'b1;
      mem_lat     = 1;
      redir_valid = 1'b1;
      redir_pc    = 64'h1002;
      exp_a(64'h1000); exp_a(64'h1004);
      exp_i(64'h1000, 32'h0001_1013);
      step();
      redir_valid = 1'b0;
      chk("misalign_pulse", 64'(misalign_err), 64'h1);
      chk("misalign_no_req", 64'(imem_req), 64'h0);
      step();
      chk("misalign_clear", 64'(misalign_err), 64'h0);
      chk("misalign_req", 64'(imem_req), 64'h1);
      chk("misalign_addr", imem_addr, 64'h1000);
      drain("misalign");

      // PC wraps from the top of the address space
      do_reset();
      rst         = 1'b0;
      id_ready    = 1'b1;
      mem_lat     = 1;
      redir_valid = 1'b1;
      redir_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      exp_a(64'hFFFF_FFFF_FFFF_FFFC); exp_a(64'h0); exp_a(64'h4);
      exp_i(64'hFFFF_FFFF_FFFF_FFFC, 32'h0001_000F);
      step();
      redir_valid = 1'b0;
      chk("wrap_aligned_err", 64'(misalign_err), 64'h0);
      drain("wrap");

      // Reset while a request is outstanding and the buffer holds an entry
      id_ready = 1'b0;
      mem_lat  = 3;
      step();
      step();
      chk("pre_rst_req", 64'(imem_req), 64'h1);
      chk("pre_rst_valid", 64'(inst_valid), 64'h1);
      rst = 1'b1;
      step();
      chk_reset_outputs("rst_wait");

      chk("addr_queue_left", 64'(exp_addr.size()), 64'h0);
      chk("inst_queue_left", 64'(exp_inst.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
